// File: rtl/step_pulse_decoder.sv
// Step/dir pulse-train decoder: synchronizes and glitch-filters an external step
// input, then tracks signed position, pulse count, step period, high time and stall.
module step_pulse_decoder #(
   parameter int WIDTH         = 16,
   parameter int GLITCH_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 clear,
   input  logic                 step_in,
   input  logic                 dir_in,
   input  logic                 pulse_invert,
   input  logic [2*WIDTH-1:0]   timeout,
   input  logic [2*WIDTH-1:0]   target_count,
   output logic [2*WIDTH-1:0]   position,
   output logic [2*WIDTH-1:0]   pulse_count,
   output logic [2*WIDTH-1:0]   period,
   output logic [2*WIDTH-1:0]   high_time,
   output logic                 period_valid,
   output logic                 target_reached,
   output logic                 stalled,
   output logic                 dir_out
);

   localparam int              CW     = 2 * WIDTH;
   localparam logic [CW-1:0]   ONE    = CW'(1);
   localparam logic [CW-1:0]   ALL1   = '1;
   localparam logic [3:0]      G_LAST = 4'(GLITCH_CYCLES - 1);

   logic          step_s1, step_s2, dir_s1, dir_s2;
   logic          filt, filt_q;
   logic [3:0]    fcnt;
   logic [CW-1:0] per_cnt, hcnt;
   logic          armed, seen_step;
   logic          step_event, filt_fall;

   // Edges are taken from the registered filter output, so an event lands one
   // cycle after filt itself changes.
   assign step_event = filt & ~filt_q;
   assign filt_fall  = ~filt & filt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         step_s1        <= 1'b0;
         step_s2        <= 1'b0;
         dir_s1         <= 1'b0;
         dir_s2         <= 1'b0;
         filt           <= 1'b0;
         filt_q         <= 1'b0;
         fcnt           <= '0;
         per_cnt        <= '0;
         hcnt           <= '0;
         armed          <= 1'b0;
         seen_step      <= 1'b0;
         position       <= '0;
         pulse_count    <= '0;
         period         <= '0;
         high_time      <= '0;
         period_valid   <= 1'b0;
         target_reached <= 1'b0;
         stalled        <= 1'b0;
         dir_out        <= 1'b0;
      end else begin
         step_s1 <= step_in ^ pulse_invert;
         step_s2 <= step_s1;
         dir_s1  <= dir_in;
         dir_s2  <= dir_s1;
         filt_q  <= filt;

         // filt follows the synced step only after GLITCH_CYCLES mismatches in a row
         if (step_s2 != filt) begin
            if (fcnt == G_LAST) begin
               filt <= step_s2;
               fcnt <= '0;
            end else begin
               fcnt <= fcnt + 4'd1;
            end
         end else begin
            fcnt <= '0;
         end

         period_valid <= 1'b0;

         if (clear) begin
            target_reached <= 1'b0;
         end else begin
            target_reached <= (target_count != '0) && (pulse_count >= target_count);
         end

         if (clear) begin
            position    <= '0;
            pulse_count <= '0;
            period      <= '0;
            high_time   <= '0;
            stalled     <= 1'b0;
            dir_out     <= 1'b0;
            per_cnt     <= '0;
            hcnt        <= '0;
            armed       <= 1'b0;
            seen_step   <= 1'b0;
         end else if (!enable) begin
            stalled <= 1'b0;
            hcnt    <= '0;
            armed   <= 1'b0;
         end else begin
            if (step_event) begin
               position <= dir_s2 ? position + ONE : position - ONE;
               if (pulse_count != ALL1) pulse_count <= pulse_count + ONE;
               dir_out   <= dir_s2;
               stalled   <= 1'b0;
               per_cnt   <= ONE;
               armed     <= 1'b1;
               seen_step <= 1'b1;
               if (armed) begin
                  period       <= per_cnt;
                  period_valid <= 1'b1;
               end
            end else begin
               if (per_cnt != ALL1) per_cnt <= per_cnt + ONE;
               if ((timeout != '0) && seen_step && (per_cnt >= timeout)) stalled <= 1'b1;
            end

            if (filt_fall) begin
               high_time <= hcnt;
               hcnt      <= '0;
            end else if (filt && (hcnt != ALL1)) begin
               hcnt <= hcnt + ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_step_pulse_decoder.sv
// Directed bench for step_pulse_decoder: an event-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_step_pulse_decoder;

   localparam int G = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        clear = 1'b0;
   logic        step_in = 1'b0;
   logic        dir_in = 1'b1;
   logic        pulse_invert = 1'b0;
   logic [31:0] timeout = '0;
   logic [31:0] target_count = '0;
   logic [31:0] position, pulse_count, period, high_time;
   logic        period_valid, target_reached, stalled, dir_out;

   int n_tests = 0;
   int n_fail  = 0;
   int pv_count = 0;

   step_pulse_decoder #(.WIDTH(16), .GLITCH_CYCLES(G)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .step_in(step_in), .dir_in(dir_in), .pulse_invert(pulse_invert),
      .timeout(timeout), .target_count(target_count),
      .position(position), .pulse_count(pulse_count), .period(period),
      .high_time(high_time), .period_valid(period_valid),
      .target_reached(target_reached), .stalled(stalled), .dir_out(dir_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (edge-indexed, event level) ----------------
   int          cyc = 0;
   bit          m_started = 0;
   logic        raw_q[$];
   logic        dir_q[$];
   logic        m_filt, m_filt_prev;
   int          m_run;
   logic [31:0] m_pos, m_cnt, m_period, m_high;
   logic        m_pv, m_tr, m_stall, m_dir, m_armed, m_seen;
   int          m_last, m_off, m_rise, m_fall;

   always @(posedge clk) begin
      logic syn, dsyn, ev, fall;
      cyc++;
      m_started = 1;
      if (rst) begin
         raw_q = '{1'b0, 1'b0};
         dir_q = '{1'b0, 1'b0};
         m_filt = 0; m_filt_prev = 0; m_run = 0;
         m_pos = 0; m_cnt = 0; m_period = 0; m_high = 0;
         m_pv = 0; m_tr = 0; m_stall = 0; m_dir = 0; m_armed = 0; m_seen = 0;
         m_last = cyc; m_off = 0; m_rise = cyc; m_fall = cyc;
      end else begin
         ev   = m_filt & ~m_filt_prev;
         fall = ~m_filt & m_filt_prev;
         syn  = raw_q[0];
         dsyn = dir_q[0];
         m_pv = 0;
         if (clear) begin
            m_pos = 0; m_cnt = 0; m_period = 0; m_high = 0;
            m_tr = 0; m_stall = 0; m_dir = 0; m_armed = 0; m_seen = 0;
            m_rise = cyc;
         end else begin
            m_tr = (target_count != 0) && (m_cnt >= target_count);
            if (!enable) begin
               m_armed = 0; m_stall = 0; m_rise = cyc; m_off++;
            end else begin
               if (ev) begin
                  m_pos = dsyn ? m_pos + 32'd1 : m_pos - 32'd1;
                  m_cnt = m_cnt + 32'd1;
                  m_dir = dsyn;
                  m_stall = 0;
                  if (m_armed) begin
                     m_period = 32'(cyc - m_last);
                     m_pv = 1;
                  end
                  m_armed = 1; m_seen = 1; m_last = cyc; m_off = 0;
               end else if (timeout != 0 && m_seen && (cyc - m_last - m_off) >= int'(timeout)) begin
                  m_stall = 1;
               end
               if (fall) m_high = 32'(m_fall - m_rise);
            end
         end
         void'(raw_q.pop_front());
         raw_q.push_back(step_in ^ pulse_invert);
         void'(dir_q.pop_front());
         dir_q.push_back(dir_in);
         m_filt_prev = m_filt;
         if (syn != m_filt) m_run++;
         else m_run = 0;
         if (m_run == G) begin
            m_filt = syn;
            m_run = 0;
            if (syn) m_rise = cyc;
            else m_fall = cyc;
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_started) begin
         check("position", position, m_pos);
         check("pulse_count", pulse_count, m_cnt);
         check("period", period, m_period);
         check("high_time", high_time, m_high);
         check("period_valid", 32'(period_valid), 32'(m_pv));
         check("target_reached", 32'(target_reached), 32'(m_tr));
         check("stalled", 32'(stalled), 32'(m_stall));
         check("dir_out", 32'(dir_out), 32'(m_dir));
         if (period_valid) pv_count++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse(input int hi, input int lo);
      @(negedge clk) step_in = ~pulse_invert;
      repeat (hi - 1) @(negedge clk);
      @(negedge clk) step_in = pulse_invert;
      repeat (lo - 1) @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk) clear = 1'b1;
      @(negedge clk) clear = 1'b0;
   endtask

   int waited;

   initial begin
      // reset
      repeat (3) @(negedge clk);
      check("rst_position", position, 32'd0);
      check("rst_count", pulse_count, 32'd0);
      check("rst_stalled", 32'(stalled), 32'd0);
      rst = 1'b0;

      // basic count with latency check on the first pulse
      pv_count = 0;
      dir_in = 1'b1;
      @(negedge clk) step_in = 1'b1;
      repeat (4) @(negedge clk);
      check("latency_before", pulse_count, 32'd0);
      step_in = 1'b0;
      @(negedge clk);
      check("latency_at4", pulse_count, 32'd1);
      repeat (14) @(negedge clk);
      repeat (9) pulse(4, 16);
      check("basic_position", position, 32'd10);
      check("basic_count", pulse_count, 32'd10);
      check("basic_period", period, 32'd20);
      check("basic_high", high_time, 32'd4);
      check("basic_strobes", 32'(pv_count), 32'd9);

      // direction reversal through zero
      do_clear();
      dir_in = 1'b1;
      repeat (5) pulse(4, 16);
      dir_in = 1'b0;
      repeat (8) pulse(4, 16);
      check("rev_position", position, 32'hFFFF_FFFD);
      check("rev_count", pulse_count, 32'd13);
      check("rev_dir", 32'(dir_out), 32'd0);

      // glitch rejection
      do_clear();
      dir_in = 1'b1;
      repeat (3) pulse(1, 10);
      check("glitch_short", pulse_count, 32'd0);
      pulse(3, 1);
      pulse(3, 12);
      check("glitch_gap", pulse_count, 32'd1);
      repeat (3) pulse(2, 10);
      check("glitch_min", pulse_count, 32'd4);
      @(negedge clk) begin pulse_invert = 1'b1; step_in = 1'b1; end
      repeat (5) @(negedge clk);
      repeat (2) pulse(1, 10);
      repeat (3) pulse(2, 10);
      check("invert_count", pulse_count, 32'd7);
      @(negedge clk) begin pulse_invert = 1'b0; step_in = 1'b0; end
      repeat (5) @(negedge clk);
      check("invert_restore", pulse_count, 32'd7);

      // stall and target
      do_clear();
      timeout = 32'd100;
      target_count = 32'd3;
      repeat (2) pulse(4, 16);
      @(negedge clk) step_in = 1'b1;
      repeat (4) @(negedge clk);
      step_in = 1'b0;
      @(negedge clk);
      check("target_count3", pulse_count, 32'd3);
      check("target_lag", 32'(target_reached), 32'd0);
      @(negedge clk);
      check("target_set", 32'(target_reached), 32'd1);
      waited = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (stalled) begin
            waited = i;
            break;
         end
      end
      check("stall_delay", 32'(waited), 32'd99);
      pulse(4, 16);
      check("stall_cleared", 32'(stalled), 32'd0);
      @(negedge clk) target_count = 32'd10;
      @(negedge clk);
      check("target_retarget", 32'(target_reached), 32'd0);
      timeout = 32'd0;
      target_count = 32'd0;

      // clear on the event cycle
      pulse(4, 16);
      @(negedge clk) step_in = 1'b1;
      repeat (4) @(negedge clk);
      step_in = 1'b0;
      clear = 1'b1;
      @(negedge clk) clear = 1'b0;
      check("clr_position", position, 32'd0);
      check("clr_count", pulse_count, 32'd0);
      repeat (20) @(negedge clk);
      check("clr_dropped", pulse_count, 32'd0);
      pv_count = 0;
      pulse(4, 16);
      check("clr_first_count", pulse_count, 32'd1);
      check("clr_first_nostrobe", 32'(pv_count), 32'd0);
      check("clr_first_period", period, 32'd0);

      // reset in the middle of a pulse, step still high on release
      @(negedge clk) step_in = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_position", position, 32'd0);
      check("midrst_count", pulse_count, 32'd0);
      check("midrst_high", high_time, 32'd0);
      check("midrst_dir", 32'(dir_out), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("midrst_noevent", pulse_count, 32'd0);
      @(negedge clk);
      check("midrst_accept", pulse_count, 32'd1);
      step_in = 1'b0;
      repeat (15) @(negedge clk);

      // enable gating
      do_clear();
      repeat (2) pulse(4, 16);
      @(negedge clk) enable = 1'b0;
      repeat (3) pulse(4, 16);
      check("dis_count", pulse_count, 32'd2);
      check("dis_position", position, 32'd2);
      check("dis_period", period, 32'd20);
      check("dis_high", high_time, 32'd4);
      @(negedge clk) enable = 1'b1;
      pv_count = 0;
      pulse(4, 16);
      check("reen_first_nostrobe", 32'(pv_count), 32'd0);
      check("reen_first_count", pulse_count, 32'd3);
      pulse(4, 16);
      check("reen_second_strobe", 32'(pv_count), 32'd1);
      check("reen_period", period, 32'd20);
      check("reen_count", pulse_count, 32'd4);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
